// File: rtl/rdi_bring_up_tx_ctrl.sv
// rdi_bring_up_tx_ctrl: TX-side sideband request engine for RDI state changes.
// Sends one request, waits for its matching response, retries on timeout.
module rdi_bring_up_tx_ctrl #(
    parameter int MSG_W          = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRY      = 2,
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES),
    localparam int RTY_W = ($clog2(MAX_RETRY + 1) > 1) ?
                           $clog2(MAX_RETRY + 1) : 1
) (
    input  logic             lclk,
    input  logic             sys_rst,
    input  logic [2:0]       i_choose,
    input  logic             i_rx_busy,
    input  logic [MSG_W-1:0] i_rx_sb_message,
    input  logic             i_rx_msg_valid,
    input  logic             i_tx_done_send,
    output logic [MSG_W-1:0] o_tx_sb_message,
    output logic             o_tx_msg_valid,
    output logic             o_done,
    output logic             o_timeout_err,
    output logic [RTY_W-1:0] o_retry_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_SEND,
        S_WAIT_RSP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           st_q, st_d;
    logic [2:0]       sel_q, sel_d;
    logic             early_q, early_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [RTY_W-1:0] retry_q, retry_d;

    logic choose_ok;
    logic rsp_match;
    logic timer_last;
    logic abort;

    function automatic logic [MSG_W-1:0] req_code(input logic [2:0] sel);
        logic [3:0] c;
        case (sel)
            3'd1:    c = 4'd1;
            3'd2:    c = 4'd11;
            3'd3:    c = 4'd9;
            3'd4:    c = 4'd7;
            3'd5:    c = 4'd13;
            default: c = 4'd0;
        endcase
        return MSG_W'(c);
    endfunction

    // Every response code is its request code plus one.
    function automatic logic [MSG_W-1:0] rsp_code(input logic [2:0] sel);
        return req_code(sel) + MSG_W'(1);
    endfunction

    assign choose_ok  = (i_choose != 3'd0) && (i_choose <= 3'd5);
    assign rsp_match  = i_rx_msg_valid &&
                        (i_rx_sb_message == rsp_code(sel_q));
    assign timer_last = (timer_q == CNT_W'(TIMEOUT_CYCLES - 1));
    // sel_q is nonzero outside IDLE, so this covers release and change.
    assign abort      = (st_q != S_IDLE) && (i_choose != sel_q);

    always_comb begin
        st_d    = st_q;
        sel_d   = sel_q;
        early_d = early_q;
        timer_d = timer_q;
        retry_d = retry_q;
        if (abort) begin
            st_d    = S_IDLE;
            early_d = 1'b0;
            timer_d = '0;
            retry_d = '0;
        end else begin
            unique case (st_q)
                S_IDLE: begin
                    early_d = 1'b0;
                    timer_d = '0;
                    retry_d = '0;
                    if (choose_ok && !i_rx_busy) begin
                        st_d  = S_REQ_SEND;
                        sel_d = i_choose;
                    end
                end
                S_REQ_SEND: begin
                    if (rsp_match) begin
                        early_d = 1'b1;
                    end
                    if (i_tx_done_send) begin
                        timer_d = '0;
                        if (early_q || rsp_match) begin
                            st_d = S_DONE;
                        end else begin
                            st_d = S_WAIT_RSP;
                        end
                    end
                end
                S_WAIT_RSP: begin
                    if (rsp_match) begin
                        st_d = S_DONE;
                    end else if (timer_last) begin
                        timer_d = '0;
                        if (retry_q < RTY_W'(MAX_RETRY)) begin
                            st_d    = S_REQ_SEND;
                            early_d = 1'b0;
                            retry_d = retry_q + 1'b1;
                        end else begin
                            st_d = S_ERROR;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_DONE:  st_d = S_DONE;
                S_ERROR: st_d = S_ERROR;
                default: st_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they move with it.
    always_ff @(posedge lclk or negedge sys_rst) begin
        if (!sys_rst) begin
            st_q            <= S_IDLE;
            sel_q           <= '0;
            early_q         <= 1'b0;
            timer_q         <= '0;
            retry_q         <= '0;
            o_tx_sb_message <= '0;
            o_tx_msg_valid  <= 1'b0;
            o_done          <= 1'b0;
            o_timeout_err   <= 1'b0;
            o_retry_cnt     <= '0;
        end else begin
            st_q            <= st_d;
            sel_q           <= sel_d;
            early_q         <= early_d;
            timer_q         <= timer_d;
            retry_q         <= retry_d;
            o_tx_msg_valid  <= (st_d == S_REQ_SEND);
            o_tx_sb_message <= (st_d == S_REQ_SEND) ? req_code(sel_d) : '0;
            o_done          <= (st_d == S_DONE);
            o_timeout_err   <= (st_d == S_ERROR);
            o_retry_cnt     <= (st_d == S_IDLE) ? '0 : retry_d;
        end
    end

endmodule

// File: doc/rdi_bring_up_tx_ctrl.md
# rdi_bring_up_tx_ctrl

Parametrised sideband request/response engine for RDI state transitions (ACTIVE, RETRAIN, LINKERROR, LINKRESET, DISABLE) on the transmit side.
- Sits between the RDI controller and the TX sideband path.
- Issues the selected request and waits for the matching response only; mismatched responses are ignored.
- Supervises the wait with a timeout and bounded retries, and reports completion or timeout failure back to the controller.

## Interface
- MSG_W, 4, sideband message code width (>=4); encodings zero-extended.
- TIMEOUT_CYCLES, 1024, lclk cycles to wait for a response per attempt (>=2).
- MAX_RETRY, 2, re-sends allowed after the first attempt (0 = no retry).
- CNT_W (localparam), $clog2(TIMEOUT_CYCLES).
- RTY_W (localparam), $clog2(MAX_RETRY+1), minimum 1.
- lclk  in  1  clock.
- sys_rst  in  1  reset; asynchronous, active-low.
- i_choose  in  3  level request: 1 ACTIVE, 2 RETRAIN, 3 LINKERROR, 4 LINKRESET, 5 DISABLE; 0 = release; 6/7 invalid.
- i_rx_busy  in  1  RX side busy; blocks new request start.
- i_rx_sb_message  in  MSG_W  received sideband message.
- i_rx_msg_valid  in  1  qualifies i_rx_sb_message.
- i_tx_done_send  in  1  TX sideband has sent the current request.
- o_tx_sb_message  out  MSG_W  request code to TX sideband.
- o_tx_msg_valid  out  1  request valid.
- o_done  out  1  matching response received.
- o_timeout_err  out  1  all attempts timed out.
- o_retry_cnt  out  RTY_W  re-sends performed in the current transaction.

## Operation
- Request/response encodings (REQ/RSP):
  - ACTIVE 1/2
  - LINKRESET 7/8
  - LINKERROR 9/10
  - RETRAIN 11/12
  - DISABLE 13/14
- The matching RSP is always REQ+1.
- The request type is latched into `sel_q` on IDLE->REQ_SEND. All matching uses `sel_q`.
- States: IDLE, REQ_SEND, WAIT_RSP, DONE, ERROR.
- IDLE: move to REQ_SEND when i_choose is in 1..5 and i_rx_busy=0. Invalid codes keep the block in IDLE. Entry clears retry count, timer and early flag.
- REQ_SEND:
  - Drives o_tx_msg_valid=1 and o_tx_sb_message=REQ(sel_q).
  - A matching response received here sets `early`.
  - On i_tx_done_send: go to DONE if `early` (or a match in the same cycle), else to WAIT_RSP.
- WAIT_RSP:
  - o_tx_msg_valid=0; the timer counts from 0.
  - A matching response goes to DONE.
  - When timer==TIMEOUT_CYCLES-1 with no match: go to REQ_SEND with retry_cnt+1 if retry_cnt<MAX_RETRY, else go to ERROR.
  - A match in the timeout cycle wins over the timeout.
- DONE: o_done=1, held until release.
- ERROR: o_timeout_err=1, held until release.
- Abort priority, highest first:
  1. i_choose==0 in any non-IDLE state -> IDLE.
  2. i_choose changed to a different nonzero value from sel_q -> IDLE; the new request then starts normally.
  3. All other transitions.
- In IDLE, all outputs are 0.

## Timing
- Outputs are registered and decoded from next state, so they change on the same lclk edge as the state.
- Reset value of every output and internal register is 0; state is IDLE.
- Request launch: i_choose sampled valid at edge N -> o_tx_msg_valid=1 and the message are valid after edge N.
- o_tx_msg_valid stays high until the edge sampling i_tx_done_send=1. The message is stable throughout.
- Response latency: a match sampled at edge M -> o_done=1 after edge M.
- Timeout: WAIT_RSP entered at edge W, no response -> re-send or ERROR after edge W+TIMEOUT_CYCLES.
- Retry: o_retry_cnt updates on the same edge that re-asserts o_tx_msg_valid.
- Release: i_choose=0 sampled at edge R -> o_done, o_timeout_err, o_tx_msg_valid and o_retry_cnt are 0 after edge R.
- i_rx_busy is only checked in IDLE. Asserting it mid-transaction has no effect.
- Asserting sys_rst at any time forces the reset values immediately (asynchronously).

## Test plan
- ACTIVE: i_choose=1, done_send after 3 cycles, RSP 2 valid 5 cycles later -> msg 1 with valid 1 for 4 cycles, then o_done=1; release -> all 0 the next cycle.
- Mismatch: i_choose=2 (RETRAIN), RX returns 8 then 12 -> 8 ignored; o_done only after 12.
- Timeout/retry: TIMEOUT_CYCLES=8, MAX_RETRY=2, i_choose=4, no response -> three sends of 7, o_retry_cnt 0->1->2, o_timeout_err=1 exactly 8 cycles after the third WAIT_RSP entry.
- Early response: RSP 14 arrives during REQ_SEND for DISABLE -> on done_send go directly to DONE; no WAIT_RSP cycle.
- Timeout-cycle race: match in the timer==TIMEOUT_CYCLES-1 cycle -> o_done=1, no retry. Separately, i_choose=0 in the same cycle as a match -> IDLE, o_done stays 0.
- Gating/reset:
  - i_rx_busy=1 with i_choose=3 -> no request; request launches the cycle after busy drops.
  - i_choose=6 -> stays IDLE.
  - sys_rst low in WAIT_RSP -> all outputs 0 immediately.
